// File: rtl/pixel_pkg.sv
// Shared types and defaults for the layer compositor.
// Holds the transaction FSM encoding and default pixel format.
package pixel_pkg;

    localparam int DEF_PIXEL_WIDTH = 12;
    localparam int DEF_TRANSPARENT = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        READ   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/layer_select.sv
// Combinational per-layer priority encoder: lowest-index requesting blob wins a layer.
// Also flags any layer claimed by two or more blobs; out-of-range layers match nothing.
import pixel_pkg::*;

module layer_select #(
    parameter int NR_OF_BLOBS  = 8,
    parameter int NR_OF_LAYERS = 4,
    parameter int ADD_WIDTH    = 16,
    parameter int LAYER_W      = $clog2(NR_OF_LAYERS)
) (
    input  logic [NR_OF_BLOBS-1:0]            request,
    input  logic [NR_OF_BLOBS*LAYER_W-1:0]    layer,
    input  logic [NR_OF_BLOBS*ADD_WIDTH-1:0]  address,
    output logic [NR_OF_LAYERS-1:0]           pend,
    output logic [NR_OF_LAYERS*ADD_WIDTH-1:0] lay_add,
    output logic                              collision
);

    always_comb begin
        pend      = '0;
        lay_add   = '0;
        collision = 1'b0;
        for (int l = 0; l < NR_OF_LAYERS; l++) begin
            // Ascending scan: the first hit owns the layer, any later hit is a collision.
            for (int b = 0; b < NR_OF_BLOBS; b++) begin
                if (request[b] && (int'(layer[b*LAYER_W +: LAYER_W]) == l)) begin
                    if (pend[l]) begin
                        collision = 1'b1;
                    end else begin
                        pend[l] = 1'b1;
                        lay_add[l*ADD_WIDTH +: ADD_WIDTH] = address[b*ADD_WIDTH +: ADD_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Composites one screen pixel per transaction: reads requested layers front to back, stops at first opaque.
// Latency 2+2k cycles (k layers read); in_ready is low for the whole transaction.
import pixel_pkg::*;

module layer_compositor #(
    parameter int NR_OF_BLOBS  = 8,
    parameter int NR_OF_LAYERS = 4,
    parameter int ADD_WIDTH    = 16,
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int TRANSPARENT  = DEF_TRANSPARENT,
    parameter int LAYER_W      = $clog2(NR_OF_LAYERS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PIXEL_WIDTH-1:0]           background,
    input  logic [NR_OF_BLOBS-1:0]           blob_request,
    input  logic [NR_OF_BLOBS*LAYER_W-1:0]   blob_layer,
    input  logic [NR_OF_BLOBS*ADD_WIDTH-1:0] blob_address,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             rd_en,
    output logic [ADD_WIDTH-1:0]             rd_add,
    input  logic [PIXEL_WIDTH-1:0]           rd_data,
    output logic [PIXEL_WIDTH-1:0]           pixel_out,
    output logic                             out_valid,
    output logic                             out_bg,
    output logic                             collision
);

    localparam logic [PIXEL_WIDTH-1:0] TRANSP = PIXEL_WIDTH'(TRANSPARENT);

    state_t                            state;
    logic [PIXEL_WIDTH-1:0]            bg_q;
    logic [NR_OF_BLOBS-1:0]            req_q;
    logic [NR_OF_BLOBS*LAYER_W-1:0]    layer_q;
    logic [NR_OF_BLOBS*ADD_WIDTH-1:0]  addr_q;
    logic [NR_OF_LAYERS-1:0]           pend_q;
    logic [NR_OF_LAYERS-1:0]           sel_pend;
    logic [NR_OF_LAYERS-1:0]           cur_mask;
    logic [NR_OF_LAYERS*ADD_WIDTH-1:0] lay_add_q;
    logic [NR_OF_LAYERS*ADD_WIDTH-1:0] sel_lay_add;
    logic                              coll_q;
    logic                              sel_coll;
    logic [ADD_WIDTH-1:0]              cur_add;
    logic [ADD_WIDTH-1:0]              rd_add_q;

    layer_select #(
        .NR_OF_BLOBS  (NR_OF_BLOBS),
        .NR_OF_LAYERS (NR_OF_LAYERS),
        .ADD_WIDTH    (ADD_WIDTH),
        .LAYER_W      (LAYER_W)
    ) u_layer_select (
        .request   (req_q),
        .layer     (layer_q),
        .address   (addr_q),
        .pend      (sel_pend),
        .lay_add   (sel_lay_add),
        .collision (sel_coll)
    );

    // Frontmost pending layer: ascending scan so the highest set bit wins.
    always_comb begin
        cur_add  = '0;
        cur_mask = '0;
        for (int l = 0; l < NR_OF_LAYERS; l++) begin
            if (pend_q[l]) begin
                cur_add     = lay_add_q[l*ADD_WIDTH +: ADD_WIDTH];
                cur_mask    = '0;
                cur_mask[l] = 1'b1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign rd_en     = (state == READ);
    assign rd_add    = rd_en ? cur_add : rd_add_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bg_q      <= '0;
            req_q     <= '0;
            layer_q   <= '0;
            addr_q    <= '0;
            pend_q    <= '0;
            lay_add_q <= '0;
            coll_q    <= 1'b0;
            rd_add_q  <= '0;
            pixel_out <= '0;
            out_bg    <= 1'b0;
            collision <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bg_q    <= background;
                        req_q   <= blob_request;
                        layer_q <= blob_layer;
                        addr_q  <= blob_address;
                        state   <= SELECT;
                    end
                end
                SELECT: begin
                    pend_q    <= sel_pend;
                    lay_add_q <= sel_lay_add;
                    coll_q    <= sel_coll;
                    if (|sel_pend) begin
                        state <= READ;
                    end else begin
                        pixel_out <= bg_q;
                        out_bg    <= 1'b1;
                        collision <= sel_coll;
                        state     <= DONE;
                    end
                end
                READ: begin
                    rd_add_q <= cur_add;
                    pend_q   <= pend_q & ~cur_mask;
                    state    <= CHECK;
                end
                CHECK: begin
                    if (rd_data != TRANSP) begin
                        pixel_out <= rd_data;
                        out_bg    <= 1'b0;
                        collision <= coll_q;
                        state     <= DONE;
                    end else if (|pend_q) begin
                        state <= READ;
                    end else begin
                        pixel_out <= bg_q;
                        out_bg    <= 1'b1;
                        collision <= coll_q;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Table-driven and randomized bench for layer_compositor against a behavioural model with a RAM model.
module tb_layer_compositor;

    logic         clk;
    logic         reset;
    logic [11:0]  background;
    logic [7:0]   blob_request;
    logic [15:0]  blob_layer;
    logic [127:0] blob_address;
    logic         in_valid;
    logic         in_ready;
    logic         rd_en;
    logic [15:0]  rd_add;
    logic [11:0]  rd_data;
    logic [11:0]  pixel_out;
    logic         out_valid;
    logic         out_bg;
    logic         collision;

    layer_compositor dut (
        .clk          (clk),
        .reset        (reset),
        .background   (background),
        .blob_request (blob_request),
        .blob_layer   (blob_layer),
        .blob_address (blob_address),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rd_en        (rd_en),
        .rd_add       (rd_add),
        .rd_data      (rd_data),
        .pixel_out    (pixel_out),
        .out_valid    (out_valid),
        .out_bg       (out_bg),
        .collision    (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] ram [0:65535];
    logic [15:0] rd_log[$];
    logic [15:0] exp_log[$];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= ram[rd_add];
            rd_log.push_back(rd_add);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] put_add(input logic [127:0] v, input int i, input logic [15:0] a);
        logic [127:0] r;
        r = v;
        r[i*16 +: 16] = a;
        return r;
    endfunction

    function automatic logic [15:0] put_lay(input logic [15:0] v, input int i, input logic [1:0] l);
        logic [15:0] r;
        r = v;
        r[i*2 +: 2] = l;
        return r;
    endfunction

    // Reference: owner of each layer is the first requester; walk layers front to back.
    task automatic model(input logic [7:0] req, input logic [15:0] lay, input logic [127:0] add,
                         input logic [11:0] bg, output logic [11:0] pix, output logic obg,
                         output logic coll, output int lat);
        int owner [4];
        int cnt [4];
        logic [15:0] a;
        for (int l = 0; l < 4; l++) begin
            owner[l] = -1;
            cnt[l]   = 0;
        end
        for (int b = 0; b < 8; b++) begin
            if (req[b]) begin
                int l;
                l = int'(lay[b*2 +: 2]);
                cnt[l]++;
                if (owner[l] < 0) owner[l] = b;
            end
        end
        coll = 1'b0;
        for (int l = 0; l < 4; l++) if (cnt[l] > 1) coll = 1'b1;
        pix = bg;
        obg = 1'b1;
        exp_log.delete();
        for (int l = 3; l >= 0; l--) begin
            if (owner[l] >= 0) begin
                a = add[owner[l]*16 +: 16];
                exp_log.push_back(a);
                if (ram[a] != 12'h000) begin
                    pix = ram[a];
                    obg = 1'b0;
                    break;
                end
            end
        end
        lat = 2 + 2 * exp_log.size();
    endtask

    task automatic run_txn(input logic [7:0] req, input logic [15:0] lay, input logic [127:0] add,
                           input logic [11:0] bg, output logic [11:0] pix, output logic obg,
                           output logic coll, output int lat);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        blob_request = req;
        blob_layer   = lay;
        blob_address = add;
        background   = bg;
        in_valid     = 1'b1;
        rd_log.delete();
        @(posedge clk);
        #1;
        chk("in_ready_busy", in_ready, 0);
        @(negedge clk);
        in_valid     = 1'b0;
        blob_request = 8'($urandom);
        blob_layer   = 16'($urandom);
        blob_address = {$urandom, $urandom, $urandom, $urandom};
        background   = 12'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got none within %0d cycles", lat);
        end
        pix  = pixel_out;
        obg  = out_bg;
        coll = collision;
        @(negedge clk);
        chk("out_valid_one_cycle", out_valid, 0);
    endtask

    typedef struct {
        logic [7:0]   req;
        logic [15:0]  lay;
        logic [127:0] add;
        logic [11:0]  bg;
        logic [11:0]  exp_pix;
        logic         exp_bg;
        logic         exp_coll;
        int           exp_lat;
        int           exp_reads;
        logic [15:0]  exp_first;
        logic [15:0]  exp_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [11:0] pix;
        logic        obg;
        logic        coll;
        int          lat;
        logic [11:0] m_pix;
        logic        m_bg;
        logic        m_coll;
        int          m_lat;
        logic [15:0] pool [16];
        logic [15:0] lay;
        logic [127:0] add;

        for (int i = 0; i < 65536; i++) ram[i] = 12'h000;
        ram[16'h0010] = 12'hF00;
        ram[16'h0020] = 12'h0AA;
        ram[16'h00F0] = 12'h0F0;
        ram[16'h0300] = 12'h333;
        ram[16'h0500] = 12'h555;

        vecs[0] = '{8'h00, 16'h0, 128'h0, 12'hABC, 12'hABC, 1'b1, 1'b0, 2, 0, 16'h0, 16'h0};

        lay = put_lay(put_lay(16'h0, 0, 2'd3), 1, 2'd0);
        add = put_add(put_add(128'h0, 0, 16'h0010), 1, 16'h0020);
        vecs[1] = '{8'h03, lay, add, 12'h777, 12'hF00, 1'b0, 1'b0, 4, 1, 16'h0010, 16'h0010};

        lay = put_lay(put_lay(16'h0, 0, 2'd3), 1, 2'd1);
        add = put_add(put_add(128'h0, 0, 16'h0000), 1, 16'h00F0);
        vecs[2] = '{8'h03, lay, add, 12'h777, 12'h0F0, 1'b0, 1'b0, 6, 2, 16'h0000, 16'h00F0};

        lay = put_lay(put_lay(16'h0, 2, 2'd2), 5, 2'd2);
        add = put_add(put_add(128'h0, 2, 16'h0300), 5, 16'h0500);
        vecs[3] = '{8'h24, lay, add, 12'h777, 12'h333, 1'b0, 1'b1, 4, 1, 16'h0300, 16'h0300};

        lay = 16'h0;
        add = 128'h0;
        for (int b = 0; b < 4; b++) begin
            lay = put_lay(lay, b, 2'(3 - b));
            add = put_add(add, b, 16'h1000 + 16'(b));
        end
        vecs[4] = '{8'h0F, lay, add, 12'h123, 12'h123, 1'b1, 1'b0, 10, 4, 16'h1000, 16'h1003};

        lay = put_lay(16'h0, 7, 2'd0);
        add = put_add(128'h0, 7, 16'h0010);
        vecs[5] = '{8'h80, lay, add, 12'h777, 12'hF00, 1'b0, 1'b0, 4, 1, 16'h0010, 16'h0010};

        reset        = 1'b1;
        in_valid     = 1'b0;
        background   = '0;
        blob_request = '0;
        blob_layer   = '0;
        blob_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_add", rd_add, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_out_bg", out_bg, 0);
        chk("rst_collision", collision, 0);

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].req, vecs[v].lay, vecs[v].add, vecs[v].bg, pix, obg, coll, lat);
            chk($sformatf("vec%0d_pixel", v), pix, vecs[v].exp_pix);
            chk($sformatf("vec%0d_bg", v), obg, vecs[v].exp_bg);
            chk($sformatf("vec%0d_coll", v), coll, vecs[v].exp_coll);
            chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
            chk($sformatf("vec%0d_nreads", v), rd_log.size(), vecs[v].exp_reads);
            if (vecs[v].exp_reads > 0 && rd_log.size() > 0) begin
                chk($sformatf("vec%0d_first_add", v), rd_log[0], vecs[v].exp_first);
                chk($sformatf("vec%0d_last_add", v), rd_log[rd_log.size()-1], vecs[v].exp_last);
            end
        end

        // Reset while the first read's data is being checked.
        begin
            int guard;
            int seen;
            @(negedge clk);
            blob_request = vecs[4].req;
            blob_layer   = vecs[4].lay;
            blob_address = vecs[4].add;
            background   = vecs[4].bg;
            in_valid     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            guard = 0;
            while (!rd_en && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("mid_reach_read", rd_en, 1);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("mid_rst_in_ready", in_ready, 1);
            chk("mid_rst_rd_en", rd_en, 0);
            chk("mid_rst_out_valid", out_valid, 0);
            chk("mid_rst_pixel_out", pixel_out, 0);
            chk("mid_rst_out_bg", out_bg, 0);
            @(negedge clk);
            reset = 1'b0;
            seen = 0;
            repeat (8) begin
                @(negedge clk);
                seen += int'(out_valid);
            end
            chk("mid_rst_no_stale_valid", seen, 0);
            run_txn(vecs[1].req, vecs[1].lay, vecs[1].add, vecs[1].bg, pix, obg, coll, lat);
            chk("post_rst_pixel", pix, 12'hF00);
            chk("post_rst_lat", lat, 4);
        end

        for (int i = 0; i < 16; i++) pool[i] = 16'h4000 + 16'(i * 3);
        for (int t = 0; t < 200; t++) begin
            logic [7:0]   rq;
            logic [15:0]  rl;
            logic [127:0] ra;
            logic [11:0]  rb;
            for (int i = 0; i < 16; i++)
                ram[pool[i]] = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
            rq = 8'($urandom);
            if (t % 4 == 0) rq = rq & 8'($urandom);
            rl = 16'($urandom);
            ra = 128'h0;
            for (int b = 0; b < 8; b++) ra = put_add(ra, b, pool[$urandom_range(0, 15)]);
            rb = 12'($urandom);
            model(rq, rl, ra, rb, m_pix, m_bg, m_coll, m_lat);
            run_txn(rq, rl, ra, rb, pix, obg, coll, lat);
            chk($sformatf("rnd%0d_pixel", t), pix, m_pix);
            chk($sformatf("rnd%0d_bg", t), obg, m_bg);
            chk($sformatf("rnd%0d_coll", t), coll, m_coll);
            chk($sformatf("rnd%0d_lat", t), lat, m_lat);
            chk($sformatf("rnd%0d_nreads", t), rd_log.size(), exp_log.size());
            for (int k = 0; k < exp_log.size() && k < rd_log.size(); k++)
                chk($sformatf("rnd%0d_read%0d", t, k), rd_log[k], exp_log[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
